// File: rtl/binary_clock_pkg.sv
// Shared types and default timing for the binary clock key front end.
// Defaults assume a 50 MHz CLOCK_50.
package binary_clock_pkg;

    typedef enum logic [2:0] {
        KS_IDLE       = 3'd0,
        KS_DB_PRESS   = 3'd1,
        KS_HOLD       = 3'd2,
        KS_REPEAT     = 3'd3,
        KS_DB_RELEASE = 3'd4
    } key_state_e;

    localparam int DEBOUNCE_CYC_DEF   = 500000;    // 10 ms
    localparam int REPEAT_DLY_CYC_DEF = 25000000;  // 500 ms
    localparam int REPEAT_CYC_DEF     = 5000000;   // 100 ms

    // Counter width sized from the largest timing constant, never below 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_channel.sv
// One pushbutton channel: 2-flop synchronizer, debounce/auto-repeat FSM and
// an output register that applies the enable gate to the increment strobe.
//
//   state         | meaning
//   --------------+------------------------------------------------------
//   KS_IDLE       | key released, waiting for a synchronized low
//   KS_DB_PRESS   | counting consecutive low samples before accepting press
//   KS_HOLD       | pressed, first pulse sent, waiting for repeat delay
//   KS_REPEAT     | pressed, pulsing every REPEAT_CYC cycles
//   KS_DB_RELEASE | counting consecutive high samples before accepting release
module key_channel
    import binary_clock_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = DEBOUNCE_CYC_DEF,
    parameter int REPEAT_DLY_CYC = REPEAT_DLY_CYC_DEF,
    parameter int REPEAT_CYC     = REPEAT_CYC_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_raw_i,
    input  logic enable_i,
    output logic pulse_o,
    output logic held_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYC, REPEAT_DLY_CYC, REPEAT_CYC);
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DB_LAST = cnt_t'(DEBOUNCE_CYC - 1);
    localparam cnt_t RD_LAST = cnt_t'(REPEAT_DLY_CYC - 1);
    localparam cnt_t RP_LAST = cnt_t'(REPEAT_CYC - 1);

    logic [1:0] sync_q;
    key_state_e state_q;
    key_state_e ret_q;
    cnt_t       db_cnt_q;
    cnt_t       rpt_cnt_q;
    logic       pulse_q;
    logic       held_q;
    logic       key_low;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

    assign key_low = ~sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_raw_i};
        end
    end

    // The repeat timer is frozen, not cleared, while a release is being
    // debounced so that a short blip resumes the cadence where it left off.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= KS_IDLE;
            ret_q     <= KS_HOLD;
            db_cnt_q  <= '0;
            rpt_cnt_q <= '0;
            pulse_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                KS_IDLE: begin
                    if (key_low) begin
                        state_q  <= KS_DB_PRESS;
                        db_cnt_q <= '0;
                    end
                end
                KS_DB_PRESS: begin
                    if (!key_low) begin
                        state_q <= KS_IDLE;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q   <= KS_HOLD;
                        held_q    <= 1'b1;
                        pulse_q   <= 1'b1;
                        rpt_cnt_q <= '0;
                    end else begin
                        db_cnt_q <= sat_inc(db_cnt_q);
                    end
                end
                KS_HOLD, KS_REPEAT: begin
                    if (!key_low) begin
                        ret_q    <= state_q;
                        state_q  <= KS_DB_RELEASE;
                        db_cnt_q <= '0;
                    end else if (rpt_cnt_q == ((state_q == KS_HOLD) ? RD_LAST : RP_LAST)) begin
                        state_q   <= KS_REPEAT;
                        pulse_q   <= 1'b1;
                        rpt_cnt_q <= '0;
                    end else begin
                        rpt_cnt_q <= sat_inc(rpt_cnt_q);
                    end
                end
                KS_DB_RELEASE: begin
                    if (key_low) begin
                        state_q  <= ret_q;
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q <= KS_IDLE;
                        held_q  <= 1'b0;
                    end else begin
                        db_cnt_q <= sat_inc(db_cnt_q);
                    end
                end
                default: state_q <= KS_IDLE;
            endcase
        end
    end

    // Suppressed strobes are simply dropped; nothing is queued for later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pulse_o <= 1'b0;
            held_o  <= 1'b0;
        end else begin
            pulse_o <= pulse_q & enable_i;
            held_o  <= held_q;
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Minute/hour pushbutton conditioner: two independent debounce and
// auto-repeat channels producing increment strobes for the clock datapath.
module key_conditioner
    import binary_clock_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = DEBOUNCE_CYC_DEF,
    parameter int REPEAT_DLY_CYC = REPEAT_DLY_CYC_DEF,
    parameter int REPEAT_CYC     = REPEAT_CYC_DEF
) (
    input  logic CLOCK_50,
    input  logic RST,
    input  logic MIN_KEY,
    input  logic HR_KEY,
    input  logic ENABLE,
    output logic min_pulse,
    output logic hr_pulse,
    output logic min_held,
    output logic hr_held
);

    key_channel #(
        .DEBOUNCE_CYC  (DEBOUNCE_CYC),
        .REPEAT_DLY_CYC(REPEAT_DLY_CYC),
        .REPEAT_CYC    (REPEAT_CYC)
    ) u_min (
        .clk_i    (CLOCK_50),
        .rst_ni   (RST),
        .key_raw_i(MIN_KEY),
        .enable_i (ENABLE),
        .pulse_o  (min_pulse),
        .held_o   (min_held)
    );

    key_channel #(
        .DEBOUNCE_CYC  (DEBOUNCE_CYC),
        .REPEAT_DLY_CYC(REPEAT_DLY_CYC),
        .REPEAT_CYC    (REPEAT_CYC)
    ) u_hr (
        .clk_i    (CLOCK_50),
        .rst_ni   (RST),
        .key_raw_i(HR_KEY),
        .enable_i (ENABLE),
        .pulse_o  (hr_pulse),
        .held_o   (hr_held)
    );

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short timing constants.
module tb_key_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic CLOCK_50 = 1'b0;
    logic RST      = 1'b0;
    logic MIN_KEY  = 1'b1;
    logic HR_KEY   = 1'b1;
    logic ENABLE   = 1'b1;
    logic min_pulse, hr_pulse, min_held, hr_held;

    int checks = 0;
    int errors = 0;

    key_conditioner #(
        .DEBOUNCE_CYC  (DB),
        .REPEAT_DLY_CYC(RD),
        .REPEAT_CYC    (RP)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RST      (RST),
        .MIN_KEY  (MIN_KEY),
        .HR_KEY   (HR_KEY),
        .ENABLE   (ENABLE),
        .min_pulse(min_pulse),
        .hr_pulse (hr_pulse),
        .min_held (min_held),
        .hr_held  (hr_held)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Cycle N is the period starting at rising edge N; inputs set before a
    // tick are seen at that edge, outputs sampled after it belong to cycle N.
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %b expected %b", tag, c, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag, input int c);
        chk({tag, "_min_pulse"}, c, min_pulse, 1'b0);
        chk({tag, "_hr_pulse"},  c, hr_pulse,  1'b0);
        chk({tag, "_min_held"},  c, min_held,  1'b0);
        chk({tag, "_hr_held"},   c, hr_held,   1'b0);
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk_all_zero("reset", 0);
        RST = 1'b1;
        repeat (3) tick();
        chk_all_zero("post_reset", 0);

        // clean press: pulses at 7, then 17 and every 3 cycles
        MIN_KEY = 1'b0;
        for (int c = 0; c <= 30; c++) begin
            tick();
            chk("clean_min_pulse", c, min_pulse,
                c == 7 || c == 17 || c == 20 || c == 23 || c == 26 || c == 29);
            chk("clean_min_held", c, min_held, c >= 7);
            chk("clean_hr_pulse", c, hr_pulse, 1'b0);
        end
        MIN_KEY = 1'b1;
        repeat (15) tick();
        chk("clean_release_held", 0, min_held, 1'b0);

        // bounce: low 3, high 1, low 3, then high
        for (int c = 0; c < 20; c++) begin
            HR_KEY = !((c < 3) || (c >= 4 && c < 7));
            tick();
            chk("bounce_hr_pulse", c, hr_pulse, 1'b0);
            chk("bounce_hr_held",  c, hr_held,  1'b0);
        end
        HR_KEY = 1'b1;

        // release glitch: 2-cycle blip while in HOLD
        for (int c = 0; c <= 16; c++) begin
            MIN_KEY = (c == 10 || c == 11);
            tick();
            if (c == 7) chk("glitch_first_pulse", c, min_pulse, 1'b1);
            if (c >= 8) begin
                chk("glitch_no_pulse", c, min_pulse, 1'b0);
                chk("glitch_held",     c, min_held,  1'b1);
            end
        end
        // long release, then a fresh press
        MIN_KEY = 1'b1;
        repeat (6) tick();
        MIN_KEY = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            tick();
            chk("repress_pulse", c, min_pulse, c == 7);
            if (c >= 1) chk("repress_held", c, min_held, c >= 7);
        end
        MIN_KEY = 1'b1;
        repeat (15) tick();

        // simultaneous press on both channels
        MIN_KEY = 1'b0;
        HR_KEY  = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            tick();
            chk("simul_min_pulse", c, min_pulse, c == 7);
            chk("simul_hr_pulse",  c, hr_pulse,  c == 7);
            chk("simul_hr_held",   c, hr_held,   c >= 7);
        end
        MIN_KEY = 1'b1;
        HR_KEY  = 1'b1;
        repeat (15) tick();

        // ENABLE low during press, raised for cycle 18
        ENABLE  = 1'b0;
        MIN_KEY = 1'b0;
        for (int c = 0; c <= 23; c++) begin
            if (c == 18) ENABLE = 1'b1;
            tick();
            chk("enable_pulse", c, min_pulse, c == 20 || c == 23);
            chk("enable_held",  c, min_held,  c >= 7);
        end
        MIN_KEY = 1'b1;
        ENABLE  = 1'b1;
        repeat (15) tick();

        // reset mid-press with key held through and after reset
        MIN_KEY = 1'b0;
        repeat (5) tick();
        RST = 1'b0;
        #1;
        chk_all_zero("rst_assert", 5);
        tick();
        chk_all_zero("rst_hold", 6);
        tick();
        chk_all_zero("rst_hold", 7);
        RST = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            tick();
            chk("rst_repress_pulse", c, min_pulse, c == 7);
            chk("rst_repress_held",  c, min_held,  c >= 7);
        end
        MIN_KEY = 1'b1;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYC, default 500000, meaning the number of consecutive stable samples needed to accept a key level change (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter REPEAT_DLY_CYC, default 25000000, meaning the cycles from the first pulse to the first auto-repeat pulse (500 ms).
REQ-003 The block SHALL have parameter REPEAT_CYC, default 5000000, meaning the cycles between successive auto-repeat pulses (100 ms).
REQ-004 CLOCK_50  input  1  sole clock; all state SHALL be updated on its rising edge.
REQ-005 RST  input  1  reset; asynchronous, active-low.
REQ-006 MIN_KEY  input  1  raw minute pushbutton; active-low (1 = released); asynchronous to CLOCK_50 and bouncing.
REQ-007 HR_KEY  input  1  raw hour pushbutton; same electrical behaviour as MIN_KEY.
REQ-008 ENABLE  input  1  1 = increment pulses allowed; 0 = pulses suppressed.
REQ-009 min_pulse  output  1  one-cycle active-high minute-increment strobe, sent to the clock datapath.
REQ-010 hr_pulse  output  1  one-cycle active-high hour-increment strobe, sent to the clock datapath.
REQ-011 min_held  output  1  debounced minute key level; 1 = pressed.
REQ-012 hr_held  output  1  debounced hour key level; 1 = pressed.

Function
REQ-013 Each key SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each key SHALL be processed by an independent FSM with states IDLE, DB_PRESS, HOLD, REPEAT and DB_RELEASE.
REQ-015 IDLE: a synchronized low SHALL move the FSM to DB_PRESS and clear the counter.
REQ-016 DB_PRESS: after DEBOUNCE_CYC consecutive low samples, the FSM SHALL go to HOLD, set held=1 and emit one pulse; any high sample SHALL return it to IDLE with no pulse.
REQ-017 HOLD: if still low REPEAT_DLY_CYC cycles after the first pulse, the FSM SHALL emit a pulse and go to REPEAT.
REQ-018 REPEAT: while the key stays low, the FSM SHALL emit one pulse every REPEAT_CYC cycles.
REQ-019 HOLD or REPEAT: a high sample SHALL move the FSM to DB_RELEASE and clear the counter.
REQ-020 DB_RELEASE: after DEBOUNCE_CYC consecutive high samples, the FSM SHALL clear held and go to IDLE; any low sample SHALL return it to its prior HOLD/REPEAT state, keeping repeat timing.
REQ-021 Latency: the first pulse SHALL assert exactly DEBOUNCE_CYC+3 cycles after the first rising edge at which the raw key is low (2 sync + DEBOUNCE_CYC count + 1 output register).
REQ-022 Pulses SHALL be exactly one cycle wide, and no two pulses from the same channel SHALL be adjacent.
REQ-023 Pulses and held SHALL be registered outputs, with no combinational path from the inputs.
REQ-024 ENABLE=0 SHALL force the pulses to 0 while the FSMs and held keep running.
REQ-025 A pulse suppressed by ENABLE SHALL be dropped and never replayed.
REQ-026 The two channels SHALL be fully independent; simultaneous pulses on both outputs in the same cycle are legal.
REQ-027 Each counter width SHALL be $clog2 of the largest parameter.
REQ-028 Each counter SHALL saturate and never wrap.

Reset
REQ-029 RST=0 SHALL asynchronously force all outputs to 0 and both FSMs to IDLE.
REQ-030 RST=0 SHALL force counters to 0 and synchronizer flops to 1 (released).
REQ-031 Reset asserted mid-press SHALL give no pulse on release of reset.
REQ-032 After reset releases with a key already held low, that key SHALL be treated as a fresh press: a pulse follows DEBOUNCE_CYC+3 cycles after the first low sample.

Structure
REQ-033 The FSM state enumeration SHALL live in the shared package binary_clock_pkg.
REQ-034 The default timing constants (DEBOUNCE_CYC, REPEAT_DLY_CYC, REPEAT_CYC) SHALL live in binary_clock_pkg.
REQ-035 One sub-module, key_channel (synchronizer + FSM + counter), SHALL be instantiated twice.

Verification (DEBOUNCE_CYC=4, REPEAT_DLY_CYC=10, REPEAT_CYC=3, ENABLE=1 unless stated)
REQ-036 Clean press: MIN_KEY low at cycle 0, held 30 cycles -> min_pulse at cycles 7, 17, 20, 23, 26, 29, ...; min_held=1 from cycle 7; hr_pulse stays 0.
REQ-037 Bounce: HR_KEY low 3 cycles, high 1, low 3, high -> hr_pulse and hr_held never assert.
REQ-038 Release glitch: press MIN_KEY to HOLD, then a 2-cycle high blip -> min_held stays 1 and no extra pulse; a 6-cycle high -> min_held falls and a re-press gives a new pulse after 7 cycles.
REQ-039 Simultaneous: MIN_KEY and HR_KEY low in the same cycle -> both pulses in cycle 7, same cycle.
REQ-040 ENABLE: ENABLE=0 throughout a press -> no pulses and min_held=1; ENABLE raised at cycle 18 -> next pulse at cycle 20, cycle-17 pulse not replayed.
REQ-041 Reset: RST pulsed low at cycle 5 of a press with the key held -> outputs 0 during reset; first pulse 7 cycles after the first low sample following RST release.
